// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one SRAM-like burst bus among the I-cache refill,
// D-cache refill/writeback and uncached requesters. Fixed priority uc > dc > ic,
// with a bounded wait counter that lifts ic to top priority after repeated losses.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req,
    input  logic              ic_wr,
    input  logic [3:0]        ic_len,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_wdata,
    output logic              ic_addr_ok,
    output logic              ic_data_ok,
    output logic [DATA_W-1:0] ic_rdata,

    input  logic              dc_req,
    input  logic              dc_wr,
    input  logic [3:0]        dc_len,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_addr_ok,
    output logic              dc_data_ok,
    output logic [DATA_W-1:0] dc_rdata,

    input  logic              uc_req,
    input  logic              uc_wr,
    input  logic [3:0]        uc_len,
    input  logic [ADDR_W-1:0] uc_addr,
    input  logic [DATA_W-1:0] uc_wdata,
    output logic              uc_addr_ok,
    output logic              uc_data_ok,
    output logic [DATA_W-1:0] uc_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_len,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [1:0] G_NONE     = 2'd0;
    localparam logic [1:0] G_IC       = 2'd1;
    localparam logic [1:0] G_DC       = 2'd2;
    localparam logic [1:0] G_UC       = 2'd3;
    localparam logic [3:0] WAIT_LIMIT = 4'(STARVE_MAX);
    localparam logic [3:0] WAIT_SAT   = 4'hF;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [3:0]        beat_q, beat_d;
    logic [3:0]        ic_wait_q, ic_wait_d;

    logic [1:0]        winner;
    logic              sel_wr;
    logic [3:0]        sel_len;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              addr_hit;
    logic              beat_hit;

    // Arbitration winner: starved ic first, then uc > dc > ic
    always_comb begin
        winner = G_NONE;
        if (ic_req && (ic_wait_q >= WAIT_LIMIT)) begin
            winner = G_IC;
        end else if (uc_req) begin
            winner = G_UC;
        end else if (dc_req) begin
            winner = G_DC;
        end else if (ic_req) begin
            winner = G_IC;
        end
    end

    // Burst fields of the currently granted requester (zero when nobody holds the bus)
    always_comb begin
        sel_wr    = 1'b0;
        sel_len   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (grant_q)
            G_IC: begin
                sel_wr    = ic_wr;
                sel_len   = ic_len;
                sel_addr  = ic_addr;
                sel_wdata = ic_wdata;
            end
            G_DC: begin
                sel_wr    = dc_wr;
                sel_len   = dc_len;
                sel_addr  = dc_addr;
                sel_wdata = dc_wdata;
            end
            G_UC: begin
                sel_wr    = uc_wr;
                sel_len   = uc_len;
                sel_addr  = uc_addr;
                sel_wdata = uc_wdata;
            end
            default: begin
                sel_wr    = 1'b0;
                sel_len   = '0;
                sel_addr  = '0;
                sel_wdata = '0;
            end
        endcase
    end

    // Next-state logic: grant, beat counter and ic starvation counter
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        beat_d    = beat_q;
        ic_wait_d = ic_wait_q;
        case (state_q)
            IDLE: begin
                if (winner != G_NONE) begin
                    grant_d = winner;
                    state_d = ADDR;
                    if (winner == G_IC) begin
                        ic_wait_d = '0;
                    end else if (ic_req && (ic_wait_q != WAIT_SAT)) begin
                        ic_wait_d = ic_wait_q + 4'd1;
                    end
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    beat_d  = sel_len;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    if (beat_q == 4'd0) begin
                        state_d = IDLE;
                        grant_d = G_NONE;
                    end else begin
                        beat_d = beat_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = G_NONE;
            end
        endcase
    end

    // State register; reset abandons any burst in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= G_NONE;
            beat_q    <= '0;
            ic_wait_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
            ic_wait_q <= ic_wait_d;
        end
    end

    // Bus handshakes are only honoured in their own phase
    assign addr_hit = (state_q == ADDR) && bus_addr_ok;
    assign beat_hit = (state_q == DATA) && bus_data_ok;

    assign ic_addr_ok = addr_hit && (grant_q == G_IC);
    assign dc_addr_ok = addr_hit && (grant_q == G_DC);
    assign uc_addr_ok = addr_hit && (grant_q == G_UC);

    assign ic_data_ok = beat_hit && (grant_q == G_IC);
    assign dc_data_ok = beat_hit && (grant_q == G_DC);
    assign uc_data_ok = beat_hit && (grant_q == G_UC);

    assign ic_rdata = ic_data_ok ? bus_rdata : '0;
    assign dc_rdata = dc_data_ok ? bus_rdata : '0;
    assign uc_rdata = uc_data_ok ? bus_rdata : '0;

    assign bus_req   = (state_q == ADDR);
    assign bus_wr    = sel_wr;
    assign bus_len   = sel_len;
    assign bus_addr  = sel_addr;
    assign bus_wdata = ((state_q == DATA) && sel_wr) ? sel_wdata : '0;

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single read, simultaneous requests,
// write data stepping, ic starvation, 16-beat burst and mid-burst reset.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req, dc_req, uc_req;
    logic        ic_wr, dc_wr, uc_wr;
    logic [3:0]  ic_len, dc_len, uc_len;
    logic [31:0] ic_addr, dc_addr, uc_addr;
    logic [31:0] ic_wdata, dc_wdata, uc_wdata;
    logic        ic_addr_ok, dc_addr_ok, uc_addr_ok;
    logic        ic_data_ok, dc_data_ok, uc_data_ok;
    logic [31:0] ic_rdata, dc_rdata, uc_rdata;
    logic        bus_req, bus_wr;
    logic [3:0]  bus_len;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic [1:0]  grant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_wr(ic_wr), .ic_len(ic_len), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
        .ic_addr_ok(ic_addr_ok), .ic_data_ok(ic_data_ok), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_wr(dc_wr), .dc_len(dc_len), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
        .uc_req(uc_req), .uc_wr(uc_wr), .uc_len(uc_len), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
        .uc_addr_ok(uc_addr_ok), .uc_data_ok(uc_data_ok), .uc_rdata(uc_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_len(bus_len), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .grant(grant), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] g, input logic v);
        case (g)
            2'd1:    ic_req = v;
            2'd2:    dc_req = v;
            default: uc_req = v;
        endcase
    endtask

    task automatic set_wdata(input logic [1:0] g, input logic [31:0] v);
        case (g)
            2'd1:    ic_wdata = v;
            2'd2:    dc_wdata = v;
            default: uc_wdata = v;
        endcase
    endtask

    function automatic logic [31:0] rd_of(input logic [1:0] g);
        case (g)
            2'd1:    return ic_rdata;
            2'd2:    return dc_rdata;
            default: return uc_rdata;
        endcase
    endfunction

    // Plays the bridge for one burst of requester g and checks every phase
    task automatic do_burst(input logic [1:0] g, input logic [3:0] len, input logic wr,
                            input logic [31:0] addr, input int addr_delay, input int exp_wait);
        int n;
        logic [2:0] onehot;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        onehot = (g == 2'd1) ? 3'b001 : (g == 2'd2) ? 3'b010 : 3'b100;
        n = 0;
        while (bus_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_latency", 64'(n), 64'(exp_wait));
        chk("grant", 64'(grant), 64'(g));
        for (int d = 0; d < addr_delay; d++) begin
            bus_data_ok = 1'b1;
            #1;
            chk("addr_wait_bus_req", 64'(bus_req), 64'd1);
            chk("addr_wait_addr_ok", 64'({uc_addr_ok, dc_addr_ok, ic_addr_ok}), 64'd0);
            chk("addr_wait_stray_data_ok", 64'({uc_data_ok, dc_data_ok, ic_data_ok}), 64'd0);
            chk("addr_wait_bus_wr", 64'(bus_wr), 64'(wr));
            chk("addr_wait_bus_len", 64'(bus_len), 64'(len));
            step();
            bus_data_ok = 1'b0;
        end
        bus_addr_ok = 1'b1;
        #1;
        chk("addr_bus_req", 64'(bus_req), 64'd1);
        chk("addr_bus_wr", 64'(bus_wr), 64'(wr));
        chk("addr_bus_len", 64'(bus_len), 64'(len));
        chk("addr_bus_addr", 64'(bus_addr), 64'(addr));
        chk("addr_bus_wdata", 64'(bus_wdata), 64'd0);
        chk("addr_ok", 64'({uc_addr_ok, dc_addr_ok, ic_addr_ok}), 64'(onehot));
        step();
        bus_addr_ok = 1'b0;
        set_req(g, 1'b0);
        for (int b = 0; b <= int'(len); b++) begin
            exp_rd = 32'h1234 + 32'(b);
            exp_wd = wr ? (32'hA0 + 32'(b)) : 32'd0;
            set_wdata(g, 32'hA0 + 32'(b));
            bus_data_ok = 1'b1;
            bus_rdata   = exp_rd;
            #1;
            chk("data_bus_req", 64'(bus_req), 64'd0);
            chk("data_ok", 64'({uc_data_ok, dc_data_ok, ic_data_ok}), 64'(onehot));
            chk("data_addr_ok", 64'({uc_addr_ok, dc_addr_ok, ic_addr_ok}), 64'd0);
            chk("rdata", 64'(rd_of(g)), 64'(exp_rd));
            chk("rdata_others", 64'(ic_rdata | dc_rdata | uc_rdata), 64'(exp_rd));
            chk("bus_wdata", 64'(bus_wdata), 64'(exp_wd));
            step();
            bus_data_ok = 1'b0;
            bus_rdata   = 32'd0;
            #1;
            chk("busy_after_beat", 64'(busy), (b < int'(len)) ? 64'd1 : 64'd0);
            chk("rdata_idle", 64'(ic_rdata | dc_rdata | uc_rdata), 64'd0);
        end
        chk("grant_after_burst", 64'(grant), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ic_req = 0; dc_req = 0; uc_req = 0;
        ic_wr = 0; dc_wr = 0; uc_wr = 0;
        ic_len = 0; dc_len = 0; uc_len = 0;
        ic_addr = 32'h1000_0000; dc_addr = 32'h2000_0000; uc_addr = 32'h3000_0000;
        ic_wdata = 32'h11; dc_wdata = 32'h22; uc_wdata = 32'h33;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_ic_wait", 64'(dut.ic_wait_q), 64'd0);
        reset = 1'b0;
        step();
        chk("post_rst_bus_req", 64'(bus_req), 64'd0);

        // Single uncached read, len 0, address accepted 2 cycles after bus_req
        uc_req = 1; uc_wr = 0; uc_len = 0; uc_addr = 32'hBFD0_0000;
        #1;
        chk("uc_req_not_yet", 64'(bus_req), 64'd0);
        do_burst(2'd3, 4'd0, 1'b0, 32'hBFD0_0000, 2, 1);

        // Simultaneous requests: uc, then dc, then ic with one idle cycle between
        ic_req = 1; ic_wr = 0; ic_len = 1; ic_addr = 32'h1000_0040;
        dc_req = 1; dc_wr = 0; dc_len = 2; dc_addr = 32'h2000_0080;
        uc_req = 1; uc_wr = 0; uc_len = 0; uc_addr = 32'hBFD0_0004;
        do_burst(2'd3, 4'd0, 1'b0, 32'hBFD0_0004, 0, 1);
        chk("ic_wait_after_1_loss", 64'(dut.ic_wait_q), 64'd1);
        do_burst(2'd2, 4'd2, 1'b0, 32'h2000_0080, 0, 1);
        chk("ic_wait_after_2_loss", 64'(dut.ic_wait_q), 64'd2);
        do_burst(2'd1, 4'd1, 1'b0, 32'h1000_0040, 0, 1);
        chk("ic_wait_cleared", 64'(dut.ic_wait_q), 64'd0);

        // D-cache write burst of 4 beats with stepping wdata
        dc_req = 1; dc_wr = 1; dc_len = 3; dc_addr = 32'h2000_0100; dc_wdata = 32'hA0;
        do_burst(2'd2, 4'd3, 1'b1, 32'h2000_0100, 1, 1);
        dc_wr = 0;

        // Starvation: ic held while uc keeps re-requesting
        ic_req = 1; ic_wr = 0; ic_len = 0; ic_addr = 32'h1000_0200;
        uc_addr = 32'hBFD0_0010; uc_len = 0;
        for (int i = 0; i < 8; i++) begin
            uc_req = 1;
            do_burst(2'd3, 4'd0, 1'b0, 32'hBFD0_0010, 0, 1);
        end
        chk("ic_wait_saturated_at_8", 64'(dut.ic_wait_q), 64'd8);
        uc_req = 1;
        do_burst(2'd1, 4'd0, 1'b0, 32'h1000_0200, 0, 1);
        chk("ic_wait_reset_on_grant", 64'(dut.ic_wait_q), 64'd0);
        do_burst(2'd3, 4'd0, 1'b0, 32'hBFD0_0010, 0, 1);

        // 16-beat I-cache read, then a stray beat while idle
        ic_req = 1; ic_wr = 0; ic_len = 15; ic_addr = 32'h1000_0400;
        do_burst(2'd1, 4'd15, 1'b0, 32'h1000_0400, 0, 1);
        bus_data_ok = 1; bus_rdata = 32'hDEAD;
        #1;
        chk("idle_stray_data_ok", 64'({uc_data_ok, dc_data_ok, ic_data_ok}), 64'd0);
        chk("idle_stray_rdata", 64'(ic_rdata | dc_rdata | uc_rdata), 64'd0);
        step();
        bus_data_ok = 0; bus_rdata = 0;
        chk("idle_stray_busy", 64'(busy), 64'd0);
        chk("idle_stray_grant", 64'(grant), 64'd0);

        // Asynchronous reset after 2 of 4 beats
        uc_req = 1; uc_wr = 0; uc_len = 3; uc_addr = 32'hBFD0_0020;
        step();
        chk("rst_test_grant", 64'(grant), 64'd3);
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; uc_req = 0;
        for (int b = 0; b < 2; b++) begin
            bus_data_ok = 1;
            #1;
            chk("rst_test_beat", 64'(uc_data_ok), 64'd1);
            step();
            bus_data_ok = 0;
        end
        #2;
        chk("rst_test_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_grant", 64'(grant), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_bus_req", 64'(bus_req), 64'd0);
        step();
        step();
        reset = 1'b0;
        uc_req = 1; uc_len = 0; uc_addr = 32'hBFD0_0030;
        do_burst(2'd3, 4'd0, 1'b0, 32'hBFD0_0030, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
